// File: rtl/alu_pkg.sv
// Shared CompALU definitions: opcode/function encodings, the fetch FSM state type
// and the legality check used by both the fetch stage and the ALU decoder.
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'd27;
    localparam logic [5:0] FN_SUB = 6'd28;
    localparam logic [5:0] FN_SRL = 6'd29;
    localparam logic [5:0] FN_SLL = 6'd30;
    localparam logic [5:0] FN_XOR = 6'd31;
    localparam logic [5:0] FN_AND = 6'd32;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_FETCH,
        FS_ISSUE,
        FS_DONE
    } fetch_state_e;

    // An R-type word is executable only if its function code is one CompALU implements.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) &&
               ((fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SRL) ||
                (fn == FN_SLL) || (fn == FN_XOR) || (fn == FN_AND));
    endfunction

endpackage

// File: rtl/alu_instr_rom.sv
// Program memory for the fetch stage: one synchronous write port and one
// synchronous read port with a registered output. Contents survive reset.
module alu_instr_rom #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/alu_instr_fetch.sv
// Issue stage for CompALU: walks the program memory from address 0, presents legal
// R-type words on a valid/ready handshake and stops on HALT or the last address.
module alu_instr_fetch
    import alu_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              bad_instr,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  skip_cnt
);

    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [DATA_W-1:0] instr_n;
    logic              bad_n;
    logic [CNT_W-1:0]  issue_n, skip_n;
    logic              rom_we;
    logic [DATA_W-1:0] rom_q;

    // The ROM is addressed with the next pc so the word is already registered
    // when FETCH is entered; this keeps one FETCH cycle per instruction.
    alu_instr_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk   (clk),
        .we    (rom_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (pc_n),
        .rdata (rom_q)
    );

    assign instr_valid = (state == FS_ISSUE);
    assign busy        = (state == FS_FETCH) || (state == FS_ISSUE);
    assign done        = (state == FS_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FS_IDLE;
            pc        <= '0;
            instr     <= '0;
            bad_instr <= 1'b0;
            issue_cnt <= '0;
            skip_cnt  <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            instr     <= instr_n;
            bad_instr <= bad_n;
            issue_cnt <= issue_n;
            skip_cnt  <= skip_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        bad_n   = bad_instr;
        issue_n = issue_cnt;
        skip_n  = skip_cnt;
        rom_we  = 1'b0;

        unique case (state)
            FS_IDLE, FS_DONE: begin
                if (start) begin
                    state_n = FS_FETCH;
                    pc_n    = '0;
                    bad_n   = 1'b0;
                    issue_n = '0;
                    skip_n  = '0;
                end else if (ld_en && !rst) begin
                    rom_we = 1'b1;
                end
            end
            FS_FETCH: begin
                if (is_legal(rom_q[DATA_W-1:DATA_W-6], rom_q[5:0])) begin
                    state_n = FS_ISSUE;
                    instr_n = rom_q;
                end else if (rom_q[DATA_W-1:DATA_W-6] == OP_HALT) begin
                    state_n = FS_DONE;
                end else begin
                    bad_n  = 1'b1;
                    skip_n = (skip_cnt == '1) ? skip_cnt : skip_cnt + CNT_W'(1);
                    if (pc == '1) begin
                        state_n = FS_DONE;
                    end else begin
                        pc_n = pc + ADDR_W'(1);
                    end
                end
            end
            FS_ISSUE: begin
                if (instr_ready) begin
                    issue_n = (issue_cnt == '1) ? issue_cnt : issue_cnt + CNT_W'(1);
                    if (pc == '1) begin
                        state_n = FS_DONE;
                    end else begin
                        state_n = FS_FETCH;
                        pc_n    = pc + ADDR_W'(1);
                    end
                end
            end
            default: state_n = FS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_fetch.sv
// Directed bench for alu_instr_fetch: small hand-assembled programs with
// expected issue streams, stalls, skips, reset abort and load gating.
module tb_alu_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        start = 1'b0;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
    logic        bad_instr;
    logic [7:0]  issue_cnt;
    logic [7:0]  skip_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] issued[$];
    logic leftZero;
    logic pcWrapped;

    localparam logic [31:0] W_ADD  = 32'h0175001B;
    localparam logic [31:0] W_SUB  = 32'h0169001C;
    localparam logic [31:0] W_HALT = 32'hFC000000;
    localparam logic [31:0] W_SRL  = 32'h0129001D;
    localparam logic [31:0] W_BAD  = 32'h0129000A;
    localparam logic [31:0] W_AND  = 32'h01290020;
    localparam logic [31:0] W_NEW  = 32'h014A581F;

    alu_instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .start       (start),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .bad_instr   (bad_instr),
        .issue_cnt   (issue_cnt),
        .skip_cnt    (skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    // One-cycle pulse of start and/or ld_en; leaves the bench just after the sampling edge.
    task automatic applyStimulus(input logic s, input logic l, input logic [4:0] a, input logic [31:0] d);
        start   = s;
        ld_en   = l;
        ld_addr = a;
        ld_data = d;
        step();
        start = 1'b0;
        ld_en = 1'b0;
    endtask

    function automatic logic [31:0] issuedAt(input int i);
        return (i < issued.size()) ? issued[i] : 32'hxxxxxxxx;
    endfunction

    task automatic waitDone(input int limit);
        for (int i = 0; i < limit && !done; i++) begin
            if (instr_valid && instr_ready) issued.push_back(instr);
            if (pc != 5'd0) leftZero = 1'b1;
            else if (leftZero) pcWrapped = 1'b1;
            step();
        end
        checkOutput("runDone", 32'(done), 32'd1);
    endtask

    task automatic startRun();
        issued.delete();
        leftZero  = 1'b0;
        pcWrapped = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_instr"}, instr, 32'd0);
        checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd0);
        checkOutput({tag, "_pc"}, 32'(pc), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_bad"}, 32'(bad_instr), 32'd0);
        checkOutput({tag, "_icnt"}, 32'(issue_cnt), 32'd0);
        checkOutput({tag, "_scnt"}, 32'(skip_cnt), 32'd0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        checkIdleZero("reset");

        // Test 1: ADD, SUB, HALT with ready held high
        applyStimulus(1'b0, 1'b1, 5'd0, W_ADD);
        applyStimulus(1'b0, 1'b1, 5'd1, W_SUB);
        applyStimulus(1'b0, 1'b1, 5'd2, W_HALT);
        instr_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0);
        checkOutput("t1_busy1", 32'(busy), 32'd1);
        checkOutput("t1_valid1", 32'(instr_valid), 32'd0);
        step();
        checkOutput("t1_valid2", 32'(instr_valid), 32'd1);
        checkOutput("t1_instr0", instr, W_ADD);
        checkOutput("t1_pc0", 32'(pc), 32'd0);
        step();
        checkOutput("t1_gap_valid", 32'(instr_valid), 32'd0);
        checkOutput("t1_gap_pc", 32'(pc), 32'd1);
        checkOutput("t1_gap_icnt", 32'(issue_cnt), 32'd1);
        step();
        checkOutput("t1_instr1", instr, W_SUB);
        checkOutput("t1_valid_i1", 32'(instr_valid), 32'd1);
        step();
        step();
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_busy_end", 32'(busy), 32'd0);
        checkOutput("t1_valid_end", 32'(instr_valid), 32'd0);
        checkOutput("t1_instr_end", instr, W_SUB);
        checkOutput("t1_icnt", 32'(issue_cnt), 32'd2);
        checkOutput("t1_pc_end", 32'(pc), 32'd2);

        // Test 2: stall five cycles on the first issue
        instr_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_valid", 32'(instr_valid), 32'd1);
            checkOutput("t2_hold_instr", instr, W_ADD);
            checkOutput("t2_hold_pc", 32'(pc), 32'd0);
            checkOutput("t2_hold_icnt", 32'(issue_cnt), 32'd0);
            step();
        end
        instr_ready = 1'b1;
        step();
        checkOutput("t2_rel_icnt", 32'(issue_cnt), 32'd1);
        checkOutput("t2_rel_valid", 32'(instr_valid), 32'd0);
        issued.delete();
        waitDone(20);
        checkOutput("t2_rest_n", 32'(issued.size()), 32'd1);
        checkOutput("t2_rest_w", issuedAt(0), W_SUB);
        checkOutput("t2_icnt", 32'(issue_cnt), 32'd2);

        // Test 3: illegal function code is skipped
        applyStimulus(1'b0, 1'b1, 5'd0, W_SRL);
        applyStimulus(1'b0, 1'b1, 5'd1, W_BAD);
        applyStimulus(1'b0, 1'b1, 5'd2, W_AND);
        applyStimulus(1'b0, 1'b1, 5'd3, W_HALT);
        startRun();
        waitDone(30);
        checkOutput("t3_n", 32'(issued.size()), 32'd2);
        checkOutput("t3_w0", issuedAt(0), W_SRL);
        checkOutput("t3_w1", issuedAt(1), W_AND);
        checkOutput("t3_bad", 32'(bad_instr), 32'd1);
        checkOutput("t3_scnt", 32'(skip_cnt), 32'd1);
        checkOutput("t3_icnt", 32'(issue_cnt), 32'd2);
        checkOutput("t3_pc", 32'(pc), 32'd3);

        // Test 4: full memory of XORs, run ends at the last address
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(i), 32'h0000001F | (32'(i) << 11));
        end
        startRun();
        waitDone(200);
        checkOutput("t4_n", 32'(issued.size()), 32'd32);
        for (int i = 0; i < 32; i++) begin
            checkOutput("t4_word", issuedAt(i), 32'h0000001F | (32'(i) << 11));
        end
        checkOutput("t4_icnt", 32'(issue_cnt), 32'd32);
        checkOutput("t4_pc", 32'(pc), 32'd31);
        checkOutput("t4_wrap", 32'(pcWrapped), 32'd0);
        checkOutput("t4_bad", 32'(bad_instr), 32'd0);
        checkOutput("t4_scnt", 32'(skip_cnt), 32'd0);

        // Test 5: reset while the second instruction is presented
        applyStimulus(1'b0, 1'b1, 5'd0, W_ADD);
        applyStimulus(1'b0, 1'b1, 5'd1, W_SUB);
        applyStimulus(1'b0, 1'b1, 5'd2, W_HALT);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0);
        step();
        step();
        step();
        checkOutput("t5_pre_valid", 32'(instr_valid), 32'd1);
        checkOutput("t5_pre_pc", 32'(pc), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkIdleZero("t5_rst");
        startRun();
        waitDone(20);
        checkOutput("t5_n", 32'(issued.size()), 32'd2);
        checkOutput("t5_w0", issuedAt(0), W_ADD);
        checkOutput("t5_w1", issuedAt(1), W_SUB);

        // Test 6: loads while busy are dropped; loads after done take effect
        instr_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0);
        step();
        applyStimulus(1'b0, 1'b1, 5'd0, W_NEW);
        checkOutput("t6_busy_instr", instr, W_ADD);
        instr_ready = 1'b1;
        issued.delete();
        waitDone(20);
        startRun();
        waitDone(20);
        checkOutput("t6_unchanged", issuedAt(0), W_ADD);
        applyStimulus(1'b0, 1'b1, 5'd0, W_NEW);
        startRun();
        waitDone(20);
        checkOutput("t6_new_w0", issuedAt(0), W_NEW);
        checkOutput("t6_new_n", 32'(issued.size()), 32'd2);
        applyStimulus(1'b1, 1'b1, 5'd0, W_AND);
        issued.delete();
        waitDone(20);
        checkOutput("t6_start_wins", issuedAt(0), W_NEW);
        startRun();
        waitDone(20);
        checkOutput("t6_start_wins2", issuedAt(0), W_NEW);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
